// File: rtl/user_table_ctrl_if.sv
// rtl/user_table_ctrl_if.sv - request/response bundle between the shop command FSM and the user table
interface user_table_ctrl_if #(
  parameter int IDX_BITS  = 4,
  parameter int NAME_BITS = 24,
  parameter int PASS_BITS = 32
);
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [1:0]           i_op;
  logic [NAME_BITS-1:0] i_name;
  logic [PASS_BITS-1:0] i_pass;
  logic                 i_perm;
  logic                 o_done;
  logic [2:0]           o_status;
  logic [IDX_BITS-1:0]  o_idx;
  logic                 o_perm;
  logic [IDX_BITS-1:0]  o_count;

  modport master (
    output i_req_valid, i_op, i_name, i_pass, i_perm,
    input  o_req_ready, o_done, o_status, o_idx, o_perm, o_count
  );

  modport slave (
    input  i_req_valid, i_op, i_name, i_pass, i_perm,
    output o_req_ready, o_done, o_status, o_idx, o_perm, o_count
  );
endinterface

// File: rtl/user_table_ctrl.sv
// rtl/user_table_ctrl.sv - user database: one-slot-per-cycle scan, then a single execute/write cycle
module user_table_ctrl #(
  parameter int                   MAX_USERS      = 5,
  parameter int                   IDX_BITS       = 4,
  parameter int                   NAME_BITS      = 24,
  parameter int                   PASS_BITS      = 32,
  parameter logic [NAME_BITS-1:0] ADMIN_USERNAME = "Adm",
  parameter logic [PASS_BITS-1:0] ADMIN_PASSWORD = "root"
) (
  input logic              i_clk,
  input logic              i_reset,
  user_table_ctrl_if.slave bus
);
  localparam int SLOT_BITS = $clog2(MAX_USERS);

  localparam logic [1:0] OP_LOGIN = 2'd0, OP_ADD = 2'd1, OP_DELETE = 2'd2, OP_FIND = 2'd3;
  localparam logic [2:0] ST_OK = 3'd0, ST_UNKNOWN = 3'd1, ST_TAKEN = 3'd2, ST_FULL = 3'd3,
                         ST_BAD_PASS = 3'd4, ST_NO_DEL_ADMIN = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC} state_t;
  state_t state_q, state_d;

  logic [MAX_USERS-1:0] valid_q, valid_d, perm_q, perm_d;
  logic [NAME_BITS-1:0] name_q [MAX_USERS];
  logic [NAME_BITS-1:0] name_d [MAX_USERS];
  logic [PASS_BITS-1:0] pass_q [MAX_USERS];
  logic [PASS_BITS-1:0] pass_d [MAX_USERS];

  logic [1:0]           op_q, op_d;
  logic [NAME_BITS-1:0] lname_q, lname_d;
  logic [PASS_BITS-1:0] lpass_q, lpass_d;
  logic                 lperm_q, lperm_d;
  logic [SLOT_BITS-1:0] ptr_q, ptr_d, hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
  logic                 hit_q, hit_d, free_q, free_d;
  logic [IDX_BITS-1:0]  count_q, count_d, idx_q, idx_d;
  logic [2:0]           status_q, status_d;
  logic                 done_q, done_d, rperm_q, rperm_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_req_valid) state_d = S_SCAN;
      S_SCAN:  if (ptr_q == SLOT_BITS'(MAX_USERS - 1)) state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_req_ready = (state_q == S_IDLE);
    bus.o_done      = done_q;
    bus.o_status    = status_q;
    bus.o_idx       = idx_q;
    bus.o_perm      = rperm_q;
    bus.o_count     = count_q;
  end

  always_comb begin
    valid_d    = valid_q;
    perm_d     = perm_q;
    name_d     = name_q;
    pass_d     = pass_q;
    op_d       = op_q;
    lname_d    = lname_q;
    lpass_d    = lpass_q;
    lperm_d    = lperm_q;
    ptr_d      = ptr_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    free_d     = free_q;
    free_idx_d = free_idx_q;
    count_d    = count_q;
    status_d   = status_q;
    idx_d      = idx_q;
    rperm_d    = rperm_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          op_d       = bus.i_op;
          lname_d    = bus.i_name;
          lpass_d    = bus.i_pass;
          lperm_d    = bus.i_perm;
          ptr_d      = '0;
          hit_d      = 1'b0;
          hit_idx_d  = '0;
          free_d     = 1'b0;
          free_idx_d = '0;
        end
      end
      S_SCAN: begin
        // First match and lowest hole win; later slots cannot override them.
        if (valid_q[ptr_q] && name_q[ptr_q] == lname_q && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = ptr_q;
        end
        if (!valid_q[ptr_q] && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
      end
      S_EXEC: begin
        done_d  = 1'b1;
        idx_d   = '0;
        rperm_d = 1'b0;
        case (op_q)
          OP_LOGIN, OP_FIND: begin
            if (!hit_q) status_d = ST_UNKNOWN;
            else if (op_q == OP_LOGIN && pass_q[hit_idx_q] != lpass_q) status_d = ST_BAD_PASS;
            else begin
              status_d = ST_OK;
              idx_d    = IDX_BITS'(hit_idx_q);
              rperm_d  = perm_q[hit_idx_q];
            end
          end
          OP_ADD: begin
            if (hit_q) status_d = ST_TAKEN;
            else if (!free_q) status_d = ST_FULL;
            else begin
              status_d           = ST_OK;
              idx_d              = IDX_BITS'(free_idx_q);
              valid_d[free_idx_q] = 1'b1;
              perm_d[free_idx_q]  = lperm_q;
              name_d[free_idx_q]  = lname_q;
              pass_d[free_idx_q]  = lpass_q;
              count_d            = count_q + 1'b1;
            end
          end
          OP_DELETE: begin
            if (!hit_q) status_d = ST_UNKNOWN;
            else if (hit_idx_q == '0) status_d = ST_NO_DEL_ADMIN;
            else begin
              status_d           = ST_OK;
              idx_d              = IDX_BITS'(hit_idx_q);
              valid_d[hit_idx_q] = 1'b0;
              count_d            = count_q - 1'b1;
            end
          end
          default: status_d = status_q;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_USERS; i++) begin
        name_q[i] <= '0;
        pass_q[i] <= '0;
      end
      name_q[0]  <= ADMIN_USERNAME;
      pass_q[0]  <= ADMIN_PASSWORD;
      valid_q    <= MAX_USERS'(1);
      perm_q     <= MAX_USERS'(1);
      op_q       <= OP_LOGIN;
      lname_q    <= '0;
      lpass_q    <= '0;
      lperm_q    <= 1'b0;
      ptr_q      <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      count_q    <= IDX_BITS'(1);
      status_q   <= ST_OK;
      idx_q      <= '0;
      rperm_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      name_q     <= name_d;
      pass_q     <= pass_d;
      valid_q    <= valid_d;
      perm_q     <= perm_d;
      op_q       <= op_d;
      lname_q    <= lname_d;
      lpass_q    <= lpass_d;
      lperm_q    <= lperm_d;
      ptr_q      <= ptr_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      free_q     <= free_d;
      free_idx_q <= free_idx_d;
      count_q    <= count_d;
      status_q   <= status_d;
      idx_q      <= idx_d;
      rperm_q    <= rperm_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_user_table_ctrl.sv
// tb/tb_user_table_ctrl.sv - directed scoreboard bench for user_table_ctrl
module tb_user_table_ctrl;
  localparam int MAX_USERS = 5;
  localparam int LAT       = MAX_USERS + 1;

  localparam logic [1:0] LOGIN = 2'd0, ADD = 2'd1, DEL = 2'd2, FIND = 2'd3;
  localparam logic [2:0] OK = 3'd0, UNKNOWN = 3'd1, TAKEN = 3'd2, FULL = 3'd3,
                         BAD_PASS = 3'd4, NO_DEL_ADMIN = 3'd5;

  typedef struct {
    logic [2:0] st;
    logic [3:0] idx;
    logic       pm;
    logic [3:0] cnt;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];

  user_table_ctrl_if #(.IDX_BITS(4), .NAME_BITS(24), .PASS_BITS(32)) bus ();

  user_table_ctrl #(.MAX_USERS(MAX_USERS), .IDX_BITS(4), .NAME_BITS(24), .PASS_BITS(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [3:0] idx, input logic pm, input logic [3:0] cnt);
    exp_t e;
    e.st = st; e.idx = idx; e.pm = pm; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_done && n < 40);
    if (!bus.o_done) chk({tag, "_timeout"}, 32'(bus.o_done), 32'd1);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_status"}, 32'(bus.o_status), 32'(e.st));
      chk({tag, "_idx"},    32'(bus.o_idx),    32'(e.idx));
      chk({tag, "_perm"},   32'(bus.o_perm),   32'(e.pm));
      chk({tag, "_count"},  32'(bus.o_count),  32'(e.cnt));
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [23:0] nm, input logic [31:0] pw, input logic pm);
    bus.i_op = op; bus.i_name = nm; bus.i_pass = pw; bus.i_perm = pm;
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [23:0] nm,
                        input logic [31:0] pw, input logic pm,
                        input logic [2:0] st, input logic [3:0] idx, input logic epm, input logic [3:0] cnt);
    int n;
    push(st, idx, epm, cnt);
    @(negedge clk);
    drive(op, nm, pw, pm);
    bus.i_req_valid = 1'b1;
    n = 0;
    while (!bus.o_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_req_ready) chk({tag, "_ready_timeout"}, 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    wait_done(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    check_rsp(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    bus.i_req_valid = 1'b0;
    drive(LOGIN, 24'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count",  32'(bus.o_count),     32'd1);
    chk("rst_done",   32'(bus.o_done),      32'd0);
    chk("rst_status", 32'(bus.o_status),    32'd0);
    chk("rst_idx",    32'(bus.o_idx),       32'd0);
    chk("rst_perm",   32'(bus.o_perm),      32'd0);
    chk("rst_ready",  32'(bus.o_req_ready), 32'd1);

    do_req("login_adm", LOGIN, "Adm", "root", 1'b0, OK, 4'd0, 1'b1, 4'd1);
    do_req("add_bob",   ADD,   "Bob", "pw12", 1'b0, OK, 4'd1, 1'b0, 4'd2);
    do_req("add_bob2",  ADD,   "Bob", "xxxx", 1'b1, TAKEN, 4'd0, 1'b0, 4'd2);
    do_req("add_cat",   ADD,   "Cat", "cat1", 1'b1, OK, 4'd2, 1'b0, 4'd3);
    do_req("add_dan",   ADD,   "Dan", "dan1", 1'b0, OK, 4'd3, 1'b0, 4'd4);
    do_req("add_eli",   ADD,   "Eli", "eli1", 1'b1, OK, 4'd4, 1'b0, 4'd5);
    do_req("add_zed",   ADD,   "Zed", "zed1", 1'b0, FULL, 4'd0, 1'b0, 4'd5);
    do_req("add_cat_f", ADD,   "Cat", "cat9", 1'b0, TAKEN, 4'd0, 1'b0, 4'd5);
    do_req("find_eli",  FIND,  "Eli", "????", 1'b0, OK, 4'd4, 1'b1, 4'd5);
    do_req("find_dan",  FIND,  "Dan", "????", 1'b0, OK, 4'd3, 1'b0, 4'd5);
    do_req("del_adm",   DEL,   "Adm", "root", 1'b0, NO_DEL_ADMIN, 4'd0, 1'b0, 4'd5);
    do_req("del_bob",   DEL,   "Bob", "pw12", 1'b0, OK, 4'd1, 1'b0, 4'd4);
    do_req("login_bob", LOGIN, "Bob", "pw12", 1'b0, UNKNOWN, 4'd0, 1'b0, 4'd4);
    do_req("add_eve",   ADD,   "Eve", "evE1", 1'b1, OK, 4'd1, 1'b0, 4'd5);
    do_req("login_eve_bad", LOGIN, "Eve", "evE2", 1'b0, BAD_PASS, 4'd0, 1'b0, 4'd5);
    do_req("login_eve", LOGIN, "Eve", "evE1", 1'b0, OK, 4'd1, 1'b1, 4'd5);
    do_req("find_eve",  FIND,  "Eve", "zzzz", 1'b0, OK, 4'd1, 1'b1, 4'd5);
    do_req("find_xyz",  FIND,  "Xyz", "zzzz", 1'b0, UNKNOWN, 4'd0, 1'b0, 4'd5);

    // Reset in the middle of an ADD scan
    @(negedge clk);
    drive(ADD, "Qqq", "qqqq", 1'b1);
    bus.i_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_count",   32'(bus.o_count), 32'd1);
    do_req("abort_find_q",   FIND,  "Qqq", "qqqq", 1'b0, UNKNOWN, 4'd0, 1'b0, 4'd1);
    do_req("abort_find_eve", FIND,  "Eve", "evE1", 1'b0, UNKNOWN, 4'd0, 1'b0, 4'd1);
    do_req("abort_login",    LOGIN, "Adm", "root", 1'b0, OK, 4'd0, 1'b1, 4'd1);

    // Valid held high while busy: second request waits for ready, then is taken once
    push(OK, 4'd0, 1'b1, 4'd1);
    push(OK, 4'd1, 1'b0, 4'd2);
    @(negedge clk);
    drive(FIND, "Adm", "----", 1'b0);
    bus.i_req_valid = 1'b1;
    @(posedge clk); #1;
    drive(ADD, "Kim", "kim1", 1'b0);
    wait_done("ovl_a", n);
    chk("ovl_a_latency", 32'(n), 32'(LAT));
    check_rsp("ovl_a");
    chk("ovl_ready_at_done", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    wait_done("ovl_b", n);
    chk("ovl_b_latency", 32'(n), 32'(LAT));
    check_rsp("ovl_b");
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.o_done) seen++;
    end
    chk("ovl_once",       32'(seen), 32'd0);
    chk("ovl_count_hold", 32'(bus.o_count), 32'd2);
    chk("sb_drained",     32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
